dram_traffic_gen: RTL and testbench

Parametrised DRAM exerciser on the system-clock side of the DRAM clock-domain crossings. It replaces button-driven single read/write poking with programmable single transactions and multi-block write sweeps and write-then-readback sweeps, with generated data patterns, read-data comparison and error statistics. It drives the request/address/data side of the synchronised DRAM read and write ports and exposes status to the seven-segment and LED logic.

---
 rtl/dram_traffic_gen.sv | 209 ++++++++++++++++++++
 tb/tb_dram_traffic_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_traffic_gen.sv
// DRAM exerciser: single reads/writes, write sweeps and write+readback sweeps with pattern checking.
// Define DRAM_TG_LFSR_EN to generate block words from a Galois LFSR instead of a counter.
module dram_traffic_gen #(
  parameter int ADDR_BITS  = 27,
  parameter int BLOCK_BITS = 512,
  parameter int STRIDE     = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [15:0]           count,
  input  logic [31:0]           seed,
  input  logic                  read_ready,
  input  logic                  write_ready,
  input  logic                  read_response,
  input  logic [BLOCK_BITS-1:0] read_data,
  output logic                  read_request,
  output logic                  write_request,
  output logic [ADDR_BITS-1:0]  read_address,
  output logic [ADDR_BITS-1:0]  write_address,
  output logic [BLOCK_BITS-1:0] write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [15:0]           error_count,
  output logic [ADDR_BITS-1:0]  first_err_addr,
  output logic [BLOCK_BITS-1:0] last_read_data
);
  localparam int LANES = BLOCK_BITS / 32;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, DONE} state_t;
  state_t state_reg, state_next;

  logic [1:0]            mode_reg;
  logic [ADDR_BITS-1:0]  base_reg, addr_reg;
  logic [15:0]           count_reg, idx_reg;
  logic [31:0]           seed_reg, word_reg, word_init, word_step;
  logic [TW-1:0]         tcnt_reg;
  logic                  seen_low_reg;
  logic [BLOCK_BITS-1:0] pattern;
  logic                  accept, issue_wr, issue_rd, capture, next_blk, restart_rd, abort;
  logic                  last_blk, timed_out, enter_issue, in_txn;

`ifdef DRAM_TG_LFSR_EN
  assign word_init = (seed == 32'd0) ? 32'd1 : seed;
  assign word_step = {1'b0, word_reg[31:1]} ^ (word_reg[0] ? 32'h8020_0003 : 32'd0);
`else
  assign word_init = seed;
  assign word_step = word_reg + 32'd1;
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign pattern[gi*32 +: 32] = word_reg + 32'(gi);
  end

  // Single transactions (modes 0/1) always count as the last block.
  assign last_blk    = !mode_reg[1] || (idx_reg == count_reg - 16'd1);
  assign timed_out   = (tcnt_reg == TW'(TIMEOUT - 1));
  assign in_txn      = (state_reg == WR_ISSUE) || (state_reg == WR_WAIT) ||
                       (state_reg == RD_ISSUE) || (state_reg == RD_WAIT);
  assign enter_issue = ((state_next == WR_ISSUE) || (state_next == RD_ISSUE)) &&
                       (state_next != state_reg);
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    capture    = 1'b0;
    next_blk   = 1'b0;
    restart_rd = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        accept = 1'b1;
        if (mode[1] && count == 16'd0) state_next = DONE;
        else if (mode == 2'd1)         state_next = RD_ISSUE;
        else                           state_next = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (write_ready) begin
          issue_wr   = 1'b1;
          state_next = WR_WAIT;
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      WR_WAIT: begin
        if (seen_low_reg && write_ready) begin
          if (!last_blk) begin
            next_blk   = 1'b1;
            state_next = WR_ISSUE;
          end else if (mode_reg == 2'd3) begin
            restart_rd = 1'b1;
            state_next = RD_ISSUE;
          end else begin
            state_next = DONE;
          end
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      RD_ISSUE: begin
        if (read_ready) begin
          issue_rd   = 1'b1;
          state_next = RD_WAIT;
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      RD_WAIT: begin
        if (read_response) begin
          capture    = 1'b1;
          state_next = (mode_reg == 2'd3) ? CHECK : DONE;
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      CHECK: begin
        if (last_blk) state_next = DONE;
        else begin
          next_blk   = 1'b1;
          state_next = RD_ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg       <= '0;
      base_reg       <= '0;
      addr_reg       <= '0;
      count_reg      <= '0;
      idx_reg        <= '0;
      seed_reg       <= '0;
      word_reg       <= '0;
      tcnt_reg       <= '0;
      seen_low_reg   <= 1'b0;
      read_request   <= 1'b0;
      write_request  <= 1'b0;
      read_address   <= '0;
      write_address  <= '0;
      write_data     <= '0;
      timeout_err    <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      last_read_data <= '0;
    end else begin
      write_request <= issue_wr;
      read_request  <= issue_rd;
      if (enter_issue)  tcnt_reg <= '0;
      else if (in_txn)  tcnt_reg <= tcnt_reg + TW'(1);
      if (issue_wr)                                  seen_low_reg <= 1'b0;
      else if (state_reg == WR_WAIT && !write_ready) seen_low_reg <= 1'b1;
      if (accept) begin
        mode_reg       <= mode;
        base_reg       <= base_addr;
        addr_reg       <= base_addr;
        count_reg      <= count;
        idx_reg        <= '0;
        seed_reg       <= word_init;
        word_reg       <= word_init;
        timeout_err    <= 1'b0;
        error_count    <= '0;
        first_err_addr <= '0;
      end
      if (issue_wr) begin
        write_address <= addr_reg;
        write_data    <= pattern;
      end
      if (issue_rd) read_address <= addr_reg;
      if (capture)  last_read_data <= read_data;
      // Compare before advancing: word_reg/addr_reg still describe block i here.
      if (state_reg == CHECK && last_read_data != pattern) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (error_count == 16'd0)    first_err_addr <= addr_reg;
      end
      if (next_blk) begin
        idx_reg  <= idx_reg + 16'd1;
        addr_reg <= addr_reg + ADDR_BITS'(STRIDE);
        word_reg <= word_step;
      end
      if (restart_rd) begin
        idx_reg  <= '0;
        addr_reg <= base_reg;
        word_reg <= seed_reg;
      end
      if (abort) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dram_traffic_gen.sv
// Bench for dram_traffic_gen: directed + randomized sweeps against a DRAM model and a reference pattern model.
module tb_dram_traffic_gen;
  localparam int AB = 27;
  localparam int BB = 128;
  localparam int STRIDE = 1;
  localparam int TIMEOUT = 64;
  localparam int RUN_LIMIT = 400;

  logic          clk = 1'b0;
  logic          rst, start, read_ready, write_ready, read_response;
  logic [1:0]    mode;
  logic [AB-1:0] base_addr;
  logic [15:0]   count;
  logic [31:0]   seed;
  logic [BB-1:0] read_data;
  logic          read_request, write_request, busy, done, timeout_err;
  logic [AB-1:0] read_address, write_address, first_err_addr;
  logic [BB-1:0] write_data, last_read_data;
  logic [15:0]   error_count;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int viol = 0;
  int rd_seen = 0;
  int corrupt_blk = -1;
  bit resp_enable = 1'b1;
  logic [BB-1:0] mem [logic [AB-1:0]];
  logic [AB-1:0] wr_addr_q[$];
  logic [BB-1:0] wr_data_q[$];
  logic [AB-1:0] rd_addr_q[$];

  dram_traffic_gen #(.ADDR_BITS(AB), .BLOCK_BITS(BB), .STRIDE(STRIDE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .count(count),
    .seed(seed), .read_ready(read_ready), .write_ready(write_ready), .read_response(read_response),
    .read_data(read_data), .read_request(read_request), .write_request(write_request),
    .read_address(read_address), .write_address(write_address), .write_data(write_data),
    .busy(busy), .done(done), .timeout_err(timeout_err), .error_count(error_count),
    .first_err_addr(first_err_addr), .last_read_data(last_read_data)
  );

  always #5 clk = ~clk;

  // Reference model: block address and data as the specification defines them.
  function automatic logic [31:0] word_at(input logic [31:0] s, input int i);
`ifdef DRAM_TG_LFSR_EN
    logic [31:0] w;
    w = (s == 32'd0) ? 32'd1 : s;
    for (int j = 0; j < i; j++) w = w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
    return w;
`else
    return s + 32'(i);
`endif
  endfunction

  function automatic logic [BB-1:0] block_of(input logic [31:0] w);
    logic [BB-1:0] b;
    for (int k = 0; k < BB / 32; k++) b[k*32 +: 32] = w + 32'(k);
    return b;
  endfunction

  function automatic logic [AB-1:0] addr_at(input logic [AB-1:0] b, input int i);
    logic [63:0] t;
    t = 64'(b) + 64'(i) * 64'(STRIDE);
    return t[AB-1:0];
  endfunction

  task automatic check(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DRAM model: reacts at negedge so the DUT always samples settled inputs.
  initial begin : dram_model
    int wr_busy, rd_cnt;
    bit rd_pend;
    logic [AB-1:0] ra;
    wr_busy = 0; rd_cnt = 0; rd_pend = 1'b0; ra = '0;
    forever begin
      @(negedge clk);
      read_response = 1'b0;
      if (write_request) begin
        write_ready = 1'b0;
        mem[write_address] = write_data;
        wr_addr_q.push_back(write_address);
        wr_data_q.push_back(write_data);
        wr_busy = $urandom_range(1, 4);
      end else if (wr_busy > 0) begin
        wr_busy--;
        if (wr_busy == 0) write_ready = 1'b1;
      end
      if (read_request) begin
        read_ready = 1'b0;
        rd_pend = 1'b1;
        rd_cnt = $urandom_range(1, 4);
        ra = read_address;
        rd_addr_q.push_back(ra);
      end else if (rd_pend) begin
        if (rd_cnt > 0) rd_cnt--;
        if (rd_cnt == 0 && resp_enable) begin
          read_data = mem.exists(ra) ? mem[ra] : '0;
          if (rd_seen == corrupt_blk) read_data[0] = ~read_data[0];
          rd_seen++;
          read_response = 1'b1;
          read_ready = 1'b1;
          rd_pend = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    bit prev_wr, prev_rd;
    prev_wr = 1'b0; prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (write_request && read_request) viol++;
      if ((prev_wr && write_request) || (prev_rd && read_request)) viol++;
      prev_wr = write_request;
      prev_rd = read_request;
      if (done) done_cnt++;
    end
  end

  task automatic run(input logic [1:0] m, input logic [AB-1:0] b, input logic [15:0] c,
                     input logic [31:0] s, input int intrude, output int lat, output int cyc);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_seen = 0;
    lat = -1; cyc = 0;
    @(negedge clk);
    mode = m; base_addr = b; count = c; seed = s; start = 1'b1;
    while (cyc < RUN_LIMIT) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == intrude) begin mode = 2'd1; start = 1'b1; end
      if (lat < 0 && (write_request || read_request)) lat = cyc;
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_sweep(input string pfx, input logic [1:0] m, input logic [AB-1:0] b,
                             input int n, input logic [31:0] s, input int cblk);
    bit hit;
    hit = (m == 2'd3) && (cblk >= 0) && (cblk < n);
    check({pfx, "_wr_count"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr_addr%0d", pfx, i), wr_addr_q[i], addr_at(b, i));
      check($sformatf("%s_wr_data%0d", pfx, i), wr_data_q[i], block_of(word_at(s, i)));
    end
    check({pfx, "_rd_count"}, rd_addr_q.size(), (m == 2'd3) ? n : 0);
    for (int i = 0; i < rd_addr_q.size() && i < n; i++)
      check($sformatf("%s_rd_addr%0d", pfx, i), rd_addr_q[i], addr_at(b, i));
    if (m == 2'd3)
      check({pfx, "_last_rd"}, last_read_data,
            block_of(word_at(s, n - 1)) ^ ((cblk == n - 1) ? BB'(1) : BB'(0)));
    check({pfx, "_err_cnt"}, error_count, hit ? 1 : 0);
    check({pfx, "_first_err"}, first_err_addr, hit ? addr_at(b, cblk) : '0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_tmo"}, timeout_err, 1'b0);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_wreq"}, write_request, 1'b0);
    check({pfx, "_rreq"}, read_request, 1'b0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_tmo"}, timeout_err, 1'b0);
    check({pfx, "_errc"}, error_count, '0);
    check({pfx, "_ferr"}, first_err_addr, '0);
    check({pfx, "_waddr"}, write_address, '0);
    check({pfx, "_raddr"}, read_address, '0);
    check({pfx, "_wdata"}, write_data, '0);
    check({pfx, "_lrd"}, last_read_data, '0);
  endtask

  initial begin : stimulus
    int lat, cyc, d0, n, cb, k, seen;
    logic [1:0] m;
    logic [AB-1:0] b;
    logic [31:0] s;
    logic [BB-1:0] exp_rd;

    rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; count = '0; seed = '0;
    write_ready = 1'b1; read_ready = 1'b1; read_response = 1'b0; read_data = '0;
    repeat (3) @(negedge clk);
    check_idle("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    // Ideal readback sweep
    d0 = done_cnt;
    run(2'd3, 27'h10, 16'd4, 32'h100, 0, lat, cyc);
    check("A_latency", lat, 2);
    check_sweep("A", 2'd3, 27'h10, 4, 32'h100, -1);
    check("A_done_once", done_cnt - d0, 1);

    // Corrupted block 2
    corrupt_blk = 2;
    run(2'd3, 27'h10, 16'd4, 32'h100, 0, lat, cyc);
    check_sweep("B", 2'd3, 27'h10, 4, 32'h100, 2);
    check("B_first_err_lit", first_err_addr, 27'h12);
    corrupt_blk = -1;

    // Address wrap
    run(2'd2, 27'h7FFFFFE, 16'd4, 32'hABCD0000, 0, lat, cyc);
    check_sweep("C", 2'd2, 27'h7FFFFFE, 4, 32'hABCD0000, -1);
    if (wr_addr_q.size() == 4) check("C_wrap", wr_addr_q[2], 27'h0);

    // Randomized sweeps
    for (int t = 0; t < 6; t++) begin
      m = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
      b = AB'($urandom_range(32'h100, 32'h3FFFFFF));
      n = $urandom_range(1, 6);
      s = $urandom;
      cb = $urandom_range(0, n);
      corrupt_blk = (cb == n) ? -1 : cb;
      run(m, b, 16'(n), s, 0, lat, cyc);
      check_sweep($sformatf("R%0d", t), m, b, n, s, corrupt_blk);
    end
    corrupt_blk = -1;

    // Single write ignores count
    b = AB'($urandom_range(32'h100, 32'h3FFFFFF));
    s = $urandom;
    run(2'd0, b, 16'd5, s, 0, lat, cyc);
    check("W_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("W_addr", wr_addr_q[0], b);
      check("W_data", wr_data_q[0], block_of(word_at(s, 0)));
    end
    check("W_rd_count", rd_addr_q.size(), 0);

    // Single read of a block written by the wrap sweep
    exp_rd = block_of(word_at(32'hABCD0000, 1));
    run(2'd1, 27'h7FFFFFF, 16'd9, 32'h0, 0, lat, cyc);
    check("S_lat", lat, 2);
    check("S_rd_count", rd_addr_q.size(), 1);
    check("S_wr_count", wr_addr_q.size(), 0);
    check("S_data", last_read_data, exp_rd);

    // Read that never responds
    resp_enable = 1'b0;
    run(2'd1, 27'h10, 16'd0, 32'h0, 0, lat, cyc);
    check("T_tmo", timeout_err, 1'b1);
    check("T_cycles", (cyc >= TIMEOUT) && (cyc <= TIMEOUT + 8), 1'b1);
    check("T_busy", busy, 1'b0);
    resp_enable = 1'b1;
    repeat (8) @(negedge clk);
    check("T_stray_ignored", last_read_data, exp_rd);

    // Empty sweep: immediate done, clears timeout
    run(2'd2, 27'h40, 16'd0, 32'h5, 0, lat, cyc);
    check("Z_done_cyc", cyc, 1);
    check("Z_tmo_clr", timeout_err, 1'b0);
    check("Z_wr", wr_addr_q.size(), 0);
    check("Z_rd", rd_addr_q.size(), 0);

    // Start while busy is ignored
    d0 = done_cnt;
    run(2'd2, 27'h200, 16'd3, 32'h77, 3, lat, cyc);
    repeat (6) @(negedge clk);
    check("I_wr", wr_addr_q.size(), 3);
    check("I_rd", rd_addr_q.size(), 0);
    check("I_done", done_cnt - d0, 1);
    check("I_busy", busy, 1'b0);

    // Reset during WR_WAIT of block 1
    seen = 0; k = 0;
    @(negedge clk);
    mode = 2'd2; base_addr = 27'h300; count = 16'd4; seed = 32'h1234; start = 1'b1;
    while (seen < 2 && k < RUN_LIMIT) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (write_request) seen++;
    end
    start = 1'b0;
    check("X_reached_blk1", seen, 2);
    #1 rst = 1'b1;
    #1;
    check_idle("X_rst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (write_request || read_request) seen++;
    end
    check("X_no_req", seen, 0);
    check("X_busy", busy, 1'b0);

    check("protocol_viol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
